// File: rtl/jk_cmd_arbiter_if.sv
// Bus between the JK command clients, the arbiter and the shared JK flip-flop.
interface jk_cmd_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [2*N-1:0] cmd;
  logic [N-1:0]   ack;
  logic           rsp_q;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           jk_j;
  logic           jk_k;
  logic           jk_q;

  modport master (
    output req, cmd, jk_q,
    input  ack, rsp_q, gnt_id, busy, jk_j, jk_k
  );

  modport slave (
    input  req, cmd, jk_q,
    output ack, rsp_q, gnt_id, busy, jk_j, jk_k
  );
endinterface

// File: rtl/jk_cmd_arbiter.sv
// Shares one external JK flip-flop among N requesters: arbitrate, drive J/K for one cycle, return Q.
// JK_CMD_ARBITER_RR_EN selects round-robin arbitration; otherwise the lowest-index request wins.
module jk_cmd_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input logic             clk,
  input logic             rst,
  jk_cmd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic           found_s;
  logic           grant_s;
  logic [IDW-1:0] winner_s;
  logic [IDW-1:0] cand_s;
  logic [1:0]     win_cmd_s;
  logic [N-1:0]   ack_r;
  logic           rsp_q_r;
  logic [IDW-1:0] gnt_id_r;
  logic           busy_r;
  logic           jk_j_r;
  logic           jk_k_r;
`ifdef JK_CMD_ARBITER_RR_EN
  logic [IDW-1:0] rr_ptr_r;
`endif

  // Winner search over the live request vector
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = '0;
`ifdef JK_CMD_ARBITER_RR_EN
    for (int k = 0; k < N; k++) begin
      cand_s   = IDW'((int'(rr_ptr_r) + k) % N);
      winner_s = (!found_s && bus.req[cand_s]) ? cand_s : winner_s;
      found_s  = found_s | bus.req[cand_s];
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      cand_s   = IDW'(k);
      winner_s = bus.req[cand_s] ? cand_s : winner_s;
      found_s  = found_s | bus.req[cand_s];
    end
`endif
  end

  assign grant_s   = (state_r == IDLE) & found_s;
  assign win_cmd_s = bus.cmd[{winner_s, 1'b0} +: 2];

  // Next-state logic for the command sequencer
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = found_s ? DRIVE : IDLE;
      DRIVE:   next_state_s = SAMPLE;
      SAMPLE:  next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered outputs; J/K are loaded only on a grant so they are live in DRIVE alone
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      ack_r    <= '0;
      rsp_q_r  <= 1'b0;
      gnt_id_r <= '0;
      busy_r   <= 1'b0;
      jk_j_r   <= 1'b0;
      jk_k_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      jk_j_r  <= grant_s & win_cmd_s[1];
      jk_k_r  <= grant_s & win_cmd_s[0];
      ack_r   <= '0;
      if (state_r == SAMPLE) begin
        ack_r[gnt_id_r] <= 1'b1;
        rsp_q_r         <= bus.jk_q;
      end
      if (grant_s) begin
        gnt_id_r <= winner_s;
      end
    end
  end

`ifdef JK_CMD_ARBITER_RR_EN
  // Round-robin pointer moves just past each winner
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (grant_s) begin
      rr_ptr_r <= (winner_s == IDW'(N - 1)) ? '0 : winner_s + 1'b1;
    end
  end
`endif

  assign bus.ack    = ack_r;
  assign bus.rsp_q  = rsp_q_r;
  assign bus.gnt_id = gnt_id_r;
  assign bus.busy   = busy_r;
  assign bus.jk_j   = jk_j_r;
  assign bus.jk_k   = jk_k_r;
endmodule

// File: doc/jk_cmd_arbiter.md
# jk_cmd_arbiter

Round-robin arbiter and sequencer that shares one external JK flip-flop among N requesters. Each requester issues a 2-bit JK command (hold/reset/set/toggle) with a req/ack handshake. The block drives the flip-flop's J/K inputs for exactly one clock, samples the resulting Q, and returns it to the winning requester. It sits between the control clients and the shared JK/T flip-flop stage of the datapath.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- IDW, 2, width of grant index; must equal clog2(N)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N  per-requester request; held high until the matching ack
- cmd  in  2N  per-requester command, slice i = cmd[2i+1:2i]; bit1 = J, bit0 = K
- ack  out  N  one-cycle completion pulse, one-hot
- rsp_q  out  1  flip-flop Q after the command; valid while ack is high
- gnt_id  out  IDW  index of the current winner; valid from DRIVE through DONE
- busy  out  1  high in any state other than IDLE
- jk_j  out  1  J input to the shared flip-flop
- jk_k  out  1  K input to the shared flip-flop
- jk_q  in  1  Q output of the shared flip-flop

## Operation
- Command encoding:
  - 00: hold
  - 01: reset (Q=0)
  - 10: set (Q=1)
  - 11: toggle
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - If any req bit is high, pick a winner, latch its cmd and index, and go to DRIVE.
  - Otherwise stay in IDLE.
- DRIVE:
  - jk_j and jk_k take the latched cmd for exactly this cycle.
  - The external flip-flop updates on the edge that ends DRIVE.
  - Next state is SAMPLE.
- SAMPLE:
  - jk_j = jk_k = 0.
  - jk_q is registered into rsp_q at the end of the cycle.
  - Next state is DONE.
- DONE:
  - ack[gnt_id] = 1 and rsp_q is valid.
  - Next state is IDLE.
- jk_j and jk_k are 0 in every state except DRIVE, so the flip-flop holds between commands.
- Arbitration is round-robin:
  - The search starts at rr_ptr and wraps modulo N.
  - After a grant, rr_ptr becomes (winner+1) mod N, with wrap at N-1 to 0.
- A requester may drop req only after it sees ack. The block samples req only in IDLE.
- If req drops mid-command (a protocol violation), the command still completes and ack still pulses.
- cmd is sampled only in IDLE. Changes to cmd after the grant are ignored.
- Requests that are high while busy wait; none is lost.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, and every output is 0 (ack, rsp_q, gnt_id, busy, jk_j, jk_k).
- Reset asserted mid-command: on the next edge the block returns to IDLE with all outputs 0.
  - No ack is issued for the aborted command.
  - The flip-flop keeps whatever value it already had.
- Latency: req first seen high in IDLE at cycle 0 → DRIVE in cycle 1 → SAMPLE in cycle 2 → ack in cycle 3.
- Throughput: one command every 4 cycles under back-to-back load.
- busy is high in cycles 1–3 and low in cycle 4, when a new arbitration takes place.
- A requester that drops req in the cycle after ack is not re-granted. Its req is already low when IDLE samples it.
- A requester that keeps req high after ack is treated as a new request and is re-arbitrated fairly.
- Simultaneous requests are resolved in a single IDLE cycle. There are no combinational paths from req to any output.

## Configuration
- Macro: JK_CMD_ARBITER_RR_EN.
- Defined: round-robin arbitration with rr_ptr, as described above.
- Not defined:
  - Fixed priority: the lowest-index asserted req wins.
  - rr_ptr is not implemented.
  - All other behaviour and timing are identical.

## Test plan
- Reset, then single command: req = 0001, cmd0 = 10 → jk_j = 1 and jk_k = 0 only in cycle 1; ack = 0001 in cycle 3 with rsp_q = 1.
- Toggle sequence: from Q = 0, requester 2 issues toggle three times (dropping and re-raising req between commands) → rsp_q = 1, 0, 1 on successive acks.
- Contention (RR_EN defined): req = 1111 held continuously, all cmds = 00 → grants in order 0, 1, 2, 3, 0; each ack is 4 cycles after the previous one.
- Contention (RR_EN undefined): req = 0110 held continuously → requester 1 wins every time and requester 2 never gets an ack.
- Reset mid-command: assert rst during SAMPLE → no ack appears; all outputs are 0 next cycle; state = IDLE; the next request is granted from index 0.
- Hold and cmd change: issue 00 (hold) while Q = 1, and change cmd after the grant → rsp_q = 1; jk_j = jk_k = 0 throughout.
